// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests to imem, a small
// {pc, word} buffer toward decode, and redirect with flush of stale fetches.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        jump_en,
   input  logic [31:0] jump_dest,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr_raw,
   output logic        enabled
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop;
   logic [CW-1:0] count;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] side_rd;
   logic [PW-1:0] side_wr;
   logic [31:0]   buf_pc   [DEPTH];
   logic [31:0]   buf_word [DEPTH];
   logic [31:0]   side_pc  [DEPTH];
   logic [CW:0]   credit_used;
   logic          accept;
   logic          push;
   logic          pop;
   logic          unused_dest_bits;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // imem handshake: a request transfers on a cycle with imem_req && imem_ready;
   // imem_req/imem_addr hold while ready is low. Responses come back in order,
   // at least one cycle later, one per imem_rvalid, and cannot be refused.
   assign credit_used      = {1'b0, inflight} + {1'b0, count};
   assign imem_req         = rstn && !jump_en && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr        = fetch_pc;
   assign accept           = imem_req && imem_ready;
   assign enabled          = rstn && (count != '0) && !stall && !jump_en;
   assign pop              = enabled;
   assign push             = imem_rvalid && (drop == '0) && !jump_en;
   assign pc               = (count != '0) ? buf_pc[head]   : '0;
   assign instr_raw        = (count != '0) ? buf_word[head] : '0;
   assign unused_dest_bits = ^jump_dest[1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         count    <= '0;
         head     <= '0;
         tail     <= '0;
         side_rd  <= '0;
         side_wr  <= '0;
      end else begin
         if (jump_en)     fetch_pc <= {jump_dest[31:2], 2'b00};
         else if (accept) fetch_pc <= fetch_pc + 32'd4;

         // The side FIFO keeps popping through a redirect so it stays aligned
         // with the responses still owed by memory.
         if (accept)      side_wr <= next_ptr(side_wr);
         if (imem_rvalid) side_rd <= next_ptr(side_rd);
         inflight <= inflight + CW'(accept) - CW'(imem_rvalid);

         if (jump_en)                          drop <= inflight - CW'(imem_rvalid);
         else if (imem_rvalid && drop != '0)   drop <= drop - CW'(1);

         if (jump_en) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
         end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage arrays need no reset: every read is qualified by count or inflight.
   always_ff @(posedge clk) begin
      if (accept) side_pc[side_wr] <= fetch_pc;
      if (push) begin
         buf_pc[tail]   <= side_pc[side_rd];
         buf_word[tail] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side memory model, expected-PC scoreboard,
// stall, redirect, random-ready and mid-stream reset scenarios.
module tb_fetch_unit;

   localparam int          DEPTH    = 3;
   localparam logic [31:0] RESET_PC = 32'h0000_0200;

   logic        clk;
   logic        rstn;
   logic        stall;
   logic        jump_en;
   logic [31:0] jump_dest;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instr_raw;
   logic        enabled;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .jump_en     (jump_en),
      .jump_dest   (jump_dest),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .instr_raw   (instr_raw),
      .enabled     (enabled)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          lat_min  = 1;
   int          lat_max  = 1;
   int          en_total = 0;
   logic        chk_credit = 1'b0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_fetch;
   logic        obs_req;
   logic        obs_en;
   logic [31:0] obs_addr;
   logic [31:0] obs_pc;
   logic [31:0] obs_instr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Memory word for an address; differs from the address so pc/word swaps show.
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic step(input logic st, input logic jmp, input logic [31:0] dest, input logic rdy);
      logic [31:0] a;
      logic [31:0] e;
      @(negedge clk);
      stall      = st;
      jump_en    = jmp;
      jump_dest  = dest;
      imem_ready = rdy;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         a = pend_addr.pop_front();
         void'(pend_due.pop_front());
         imem_rvalid = 1'b1;
         imem_rdata  = mem_data(a);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      #1;
      obs_req   = imem_req;
      obs_en    = enabled;
      obs_addr  = imem_addr;
      obs_pc    = pc;
      obs_instr = instr_raw;
      if (jmp) begin
         check("req_in_jump", imem_req, 32'd0);
         check("en_in_jump", enabled, 32'd0);
      end
      if (imem_req && imem_ready) begin
         check("fetch_addr", imem_addr, exp_fetch);
         pend_addr.push_back(imem_addr);
         pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
         exp_q.push_back(exp_fetch);
         exp_fetch += 32'd4;
      end
      if (enabled) begin
         en_total++;
         if (exp_q.size() == 0) begin
            check("enabled_when_empty", enabled, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pc", pc, e);
            check("instr", instr_raw, mem_data(e));
         end
      end
      if (jmp) begin
         exp_q.delete();
         exp_fetch = {dest[31:2], 2'b00};
      end
      if (chk_credit) check("credit", 32'(exp_q.size() <= DEPTH), 32'd1);
      @(posedge clk);
      cyc++;
   endtask

   // ---------------- reset: asserted off-edge, released just after a posedge ----------------
   task automatic do_reset();
      @(negedge clk);
      #2;
      rstn        = 1'b0;
      stall       = 1'b0;
      jump_en     = 1'b0;
      jump_dest   = '0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      #1;
      check("rst_req", imem_req, 32'd0);
      check("rst_en", enabled, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_instr", instr_raw, 32'd0);
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      exp_fetch = RESET_PC;
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
      cyc = 0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n_en;
      int en_before;
      rstn        = 1'b0;
      stall       = 1'b0;
      jump_en     = 1'b0;
      jump_dest   = '0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      exp_fetch   = RESET_PC;

      // Streaming from reset, 1-cycle memory: enabled from the third cycle on.
      do_reset();
      step(1'b0, 1'b0, '0, 1'b1);
      check("first_req", obs_req, 32'd1);
      check("first_addr", obs_addr, RESET_PC);
      check("c0_en", obs_en, 32'd0);
      step(1'b0, 1'b0, '0, 1'b1);
      check("c1_en", obs_en, 32'd0);
      n_en = 0;
      for (int i = 2; i < 12; i++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         if (obs_en) n_en++;
      end
      check("steady_en_count", n_en, 32'd10);

      // Stall for 5 cycles: one more request fills the credit, then req drops.
      step(1'b1, 1'b0, '0, 1'b1);
      check("stall_s0_req", obs_req, 32'd1);
      for (int i = 1; i < 5; i++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         check("stall_req", obs_req, 32'd0);
         check("stall_en", obs_en, 32'd0);
         check("stall_pc_hold", obs_pc, exp_q[0]);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      check("resume_en", obs_en, 32'd1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

      // Redirect with 2 in flight and 1 buffered (2-cycle memory), jump in cycle 3.
      do_reset();
      lat_min = 2;
      lat_max = 2;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
      lat_min = 1;
      lat_max = 1;
      step(1'b0, 1'b1, 32'h0000_1003, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("jump_req", obs_req, 32'd1);
      check("jump_addr", obs_addr, 32'h0000_1000);
      check("jump_c4_en", obs_en, 32'd0);
      step(1'b0, 1'b0, '0, 1'b1);
      check("jump_c5_en", obs_en, 32'd0);
      step(1'b0, 1'b0, '0, 1'b1);
      check("jump_c6_en", obs_en, 32'd1);
      check("jump_first_pc", obs_pc, 32'h0000_1000);
      step(1'b0, 1'b0, '0, 1'b1);
      check("jump_second_pc", obs_pc, 32'h0000_1004);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

      // Redirect under stall while a response arrives: word dropped, buffer empty.
      step(1'b1, 1'b1, 32'h0000_2000, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("js_en", obs_en, 32'd0);
      check("js_pc", obs_pc, 32'd0);
      check("js_instr", obs_instr, 32'd0);
      check("js_addr", obs_addr, 32'h0000_2000);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);
      check("js_next_pc", obs_pc, 32'h0000_2010);

      // Random ready, 1-4 cycle latency, occasional stall.
      lat_min    = 1;
      lat_max    = 4;
      chk_credit = 1'b1;
      en_before  = en_total;
      for (int i = 0; i < 300; i++)
         step($urandom_range(3, 0) == 0, 1'b0, '0, 1'($urandom_range(1, 0)));
      chk_credit = 1'b0;
      check("random_progress", 32'(en_total - en_before > 20), 32'd1);

      // Mid-stream reset: outputs clear at once, fetch restarts at RESET_PC.
      lat_min = 1;
      lat_max = 1;
      do_reset();
      step(1'b0, 1'b0, '0, 1'b1);
      check("rerst_req", obs_req, 32'd1);
      check("rerst_addr", obs_addr, RESET_PC);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
      check("rerst_pc", obs_pc, RESET_PC + 32'd8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
